// File: rtl/secure_reg_arbiter.sv
// secure_reg_arbiter
//   Shares one secure_register among NUM_REQ requesters. Requesters are
//   granted in round-robin order. Only thread ID 0 may touch the register.
//   Other threads get an error response, the register is never strobed for
//   them, and each refusal bumps a saturating violation counter.
//
//   Transaction flow: IDLE (arbitrate + latch) -> ACCESS (gnt, register
//   strobe) -> RESP (rsp_valid). This gives one transaction per 3 cycles.
//
// Ports
//   clk, rst_n      : rising-edge clock, synchronous active-low reset
//   req/req_wr      : per-requester request level and write flag
//   req_tid         : packed thread IDs, requester i at [i*TID_WIDTH +: TID_WIDTH]
//   req_wdata       : packed write data, same packing
//   gnt             : one-hot grant, asserted during ACCESS
//   rsp_valid       : one-hot response strobe, asserted during RESP
//   rsp_err         : access denied, qualifies rsp_valid
//   rsp_rdata       : read data, qualifies rsp_valid
//   viol_count      : saturating count of denied requests
//   reg_*           : drive the secure register's access_en/wr_en/thread_id/data_in
//   reg_data_out    : the register's current contents
module secure_reg_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TID_WIDTH  = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ-1:0]              req_wr,
  input  logic [NUM_REQ*TID_WIDTH-1:0]    req_tid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]              gnt,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic                            rsp_err,
  output logic [DATA_WIDTH-1:0]           rsp_rdata,
  output logic [7:0]                      viol_count,
  output logic                            reg_access_en,
  output logic                            reg_wr_en,
  output logic [TID_WIDTH-1:0]            reg_thread_id,
  output logic [DATA_WIDTH-1:0]           reg_data_in,
  input  logic [DATA_WIDTH-1:0]           reg_data_out
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  // Unpacked views of the per-requester payload buses
  logic [TID_WIDTH-1:0]  tid_arr   [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign tid_arr[gi]   = req_tid[gi*TID_WIDTH +: TID_WIDTH];
    assign wdata_arr[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   wr_q, wr_d;
  logic [TID_WIDTH-1:0]   tid_q, tid_d;
  logic [NUM_REQ-1:0]     gnt_q, gnt_d;
  logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
  logic                   rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic [7:0]             viol_q, viol_d;
  logic                   reg_access_en_q, reg_access_en_d;
  logic                   reg_wr_en_q, reg_wr_en_d;
  logic [TID_WIDTH-1:0]   reg_thread_id_q, reg_thread_id_d;
  logic [DATA_WIDTH-1:0]  reg_data_in_q, reg_data_in_d;

  // Round-robin winner: first set req scanning upward from rr_ptr, wrapping.
  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] cand;
  int               j;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    j         = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(rr_ptr_q) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      cand = IDX_W'(j);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state logic. Every output is a flop, loaded one edge ahead of the
  // state it belongs to, so nothing combinational reaches the ports.
  always_comb begin
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    idx_d           = idx_q;
    wr_d            = wr_q;
    tid_d           = tid_q;
    rsp_rdata_d     = rsp_rdata_q;
    viol_d          = viol_q;
    gnt_d           = '0;
    rsp_valid_d     = '0;
    rsp_err_d       = 1'b0;
    reg_access_en_d = 1'b0;
    reg_wr_en_d     = 1'b0;
    reg_thread_id_d = '0;
    reg_data_in_d   = '0;

    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          idx_d          = win_idx;
          wr_d           = req_wr[win_idx];
          tid_d          = tid_arr[win_idx];
          rr_ptr_d       = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
          gnt_d[win_idx] = 1'b1;
          // Register pins are only driven for the privileged thread
          if (tid_arr[win_idx] == '0) begin
            reg_access_en_d = 1'b1;
            reg_wr_en_d     = req_wr[win_idx];
            reg_thread_id_d = tid_arr[win_idx];
            reg_data_in_d   = wdata_arr[win_idx];
          end
          state_d = S_ACCESS;
        end
      end

      S_ACCESS: begin
        rsp_valid_d[idx_q] = 1'b1;
        if (tid_q == '0) begin
          rsp_rdata_d = wr_q ? '0 : reg_data_out;
        end else begin
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          viol_d      = (viol_q == 8'hFF) ? viol_q : viol_q + 8'd1;
        end
        state_d = S_RESP;
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      rr_ptr_q        <= '0;
      idx_q           <= '0;
      wr_q            <= 1'b0;
      tid_q           <= '0;
      gnt_q           <= '0;
      rsp_valid_q     <= '0;
      rsp_err_q       <= 1'b0;
      rsp_rdata_q     <= '0;
      viol_q          <= '0;
      reg_access_en_q <= 1'b0;
      reg_wr_en_q     <= 1'b0;
      reg_thread_id_q <= '0;
      reg_data_in_q   <= '0;
    end else begin
      state_q         <= state_d;
      rr_ptr_q        <= rr_ptr_d;
      idx_q           <= idx_d;
      wr_q            <= wr_d;
      tid_q           <= tid_d;
      gnt_q           <= gnt_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_err_q       <= rsp_err_d;
      rsp_rdata_q     <= rsp_rdata_d;
      viol_q          <= viol_d;
      reg_access_en_q <= reg_access_en_d;
      reg_wr_en_q     <= reg_wr_en_d;
      reg_thread_id_q <= reg_thread_id_d;
      reg_data_in_q   <= reg_data_in_d;
    end
  end

  assign gnt           = gnt_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_err       = rsp_err_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign viol_count    = viol_q;
  assign reg_access_en = reg_access_en_q;
  assign reg_wr_en     = reg_wr_en_q;
  assign reg_thread_id = reg_thread_id_q;
  assign reg_data_in   = reg_data_in_q;

endmodule

// File: doc/secure_reg_arbiter.md
# secure_reg_arbiter

Arbiter and access controller that shares a single `secure_register` instance among `NUM_REQ` requesters. It grants requesters in round-robin order and enforces the register's access policy: only thread ID 0 may touch the register. Requests from any other thread are refused with an error response, the register is never strobed for them, and each refusal is counted. It sits between the requester bus and the register's `access_en`/`wr_en`/`thread_id`/`data_in` pins.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_WIDTH`, 32: register data width.
- `TID_WIDTH`, 4: thread ID width.

- `clk` input 1: single clock; all logic is rising-edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `req` input NUM_REQ: per-requester request, level.
- `req_wr` input NUM_REQ: 1 = write, 0 = read.
- `req_tid` input NUM_REQ*TID_WIDTH: thread ID of requester i at bits [i*TID_WIDTH +: TID_WIDTH].
- `req_wdata` input NUM_REQ*DATA_WIDTH: write data, packed the same way.
- `gnt` output NUM_REQ: one-hot grant, high for one cycle.
- `rsp_valid` output NUM_REQ: one-hot response strobe, high for one cycle.
- `rsp_err` output 1: qualifies `rsp_valid`; 1 = access denied.
- `rsp_rdata` output DATA_WIDTH: read data, qualified by `rsp_valid`.
- `viol_count` output 8: saturating count of denied requests.
- `reg_access_en` output 1: to the register's `access_en`.
- `reg_wr_en` output 1: to the register's `wr_en`.
- `reg_thread_id` output TID_WIDTH: to the register's `thread_id`.
- `reg_data_in` output DATA_WIDTH: to the register's `data_in`.
- `reg_data_out` input DATA_WIDTH: from the register's `data_out`; combinational view of its current contents.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - If any `req` is high, select the winner: the first set bit scanning upward from `rr_ptr`, wrapping from index NUM_REQ-1 back to 0.
  - Latch the winner's index, `req_wr`, `req_tid` and `req_wdata`.
  - Set `rr_ptr` = (winner+1) mod NUM_REQ, then go to ACCESS.
  - If no `req` is high, stay in IDLE.
- **ACCESS**
  - `gnt[idx]` = 1.
  - If the latched tid == 0:
    - `reg_access_en` = 1 and `reg_wr_en` = latched wr.
    - `reg_thread_id` = latched tid and `reg_data_in` = latched wdata.
    - For a read, capture `reg_data_out` into `rsp_rdata` at the end of this cycle.
    - For a write, `rsp_rdata` = 0.
  - If the latched tid != 0:
    - `reg_access_en` = `reg_wr_en` = 0.
    - Set the error flag; `rsp_rdata` = 0.
    - Increment `viol_count`, saturating at 255.
  - Always go to RESP.
- **RESP**
  - `rsp_valid[idx]` = 1 and `rsp_err` = the error flag.
  - Go to IDLE.
- Register-side outputs:
  - `reg_access_en` and `reg_wr_en` are 0 in every state other than ACCESS.
  - `reg_data_in` and `reg_thread_id` are 0 outside ACCESS.
- Requester obligations:
  - Hold `req` and its payload until `gnt`.
  - Deassert `req` in the cycle after `gnt`, or it will be arbitrated again.
- Dropping `req` after it has been latched does not abort the transaction; it completes normally.
- Requests arriving in ACCESS or RESP are ignored until the next IDLE.

## Timing
- Reset (`rst_n` = 0 at a rising edge):
  - State → IDLE, `rr_ptr` → 0, `viol_count` → 0.
  - `gnt`, `rsp_valid`, `rsp_err`, `rsp_rdata`, `reg_*` outputs → 0.
  - Reset mid-transaction drops the transaction: no `rsp_valid` is produced and no register strobe follows.
- Latency:
  - `req` sampled high in IDLE at cycle T → `gnt` in T+1 (ACCESS) → `rsp_valid` in T+2 (RESP).
  - Back-to-back throughput is one transaction per 3 cycles; the next IDLE is T+3.
- All outputs are registered or decoded from state and latched fields only. There is no combinational path from `req*` to any output.
- A register write takes effect at the rising edge that ends ACCESS.
- A read issued in the next transaction returns the new value.
- `viol_count` updates at the edge ending ACCESS and stays at 255 once saturated.
- Simultaneous requests: exactly one `gnt` per transaction, chosen by `rr_ptr`. No requester waits more than NUM_REQ-1 transactions while its `req` stays high.

## Test plan
- **Reset values:** assert `rst_n` = 0 for 2 cycles while `req` = 4'b1111. All outputs are 0, and no `gnt` appears until the first IDLE cycle after release.
- **Write then read by tid 0:** req0 writes 0xDEADBEEF with tid 0, then req0 reads.
  - `reg_access_en` = `reg_wr_en` = 1 in ACCESS of the first transaction.
  - The read's `rsp_rdata` = 0xDEADBEEF with `rsp_err` = 0.
  - Each transaction shows `gnt` at T+1 and `rsp_valid` at T+2.
- **Denied access:** req2 writes 0x12345678 with tid 3.
  - `reg_access_en` stays 0 and `rsp_err` = 1 with `rsp_rdata` = 0.
  - `viol_count` = 1.
  - A following tid-0 read returns the prior value, unchanged.
- **Round-robin fairness:** `req` = 4'b1111 held continuously with tid 0.
  - Grant order is 0, 1, 2, 3, 0, with one `gnt` every 3 cycles.
  - Then hold `req` = 4'b1010 with `rr_ptr` = 2: grant order is 3, 1, 3.
- **Saturation:** 260 denied requests (tid 5). `viol_count` reaches 255 and stays at 255.
- **Reset mid-transaction:** pull `rst_n` low during ACCESS of a tid-0 write. No `rsp_valid` is produced, `rr_ptr` = 0 afterwards, and the next grant goes to the lowest-index active requester.
